// File: rtl/tx_frame_ctrl.sv
// Framing controller feeding a parallel-to-serial shift buffer: emits
// preamble, sync, length, payload and CRC-8 as one gapless bit stream.
module tx_frame_ctrl #(
    parameter int unsigned PREAMBLE_BYTES = 2,
    parameter logic [7:0]  PREAMBLE_PAT   = 8'hAA,
    parameter logic [7:0]  SYNC_WORD      = 8'hD3,
    parameter logic [7:0]  CRC_POLY       = 8'h07,
    parameter logic [7:0]  CRC_INIT       = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] frame_len,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic [7:0] buf_din,
    output logic       buf_load,
    output logic       buf_en,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    typedef enum logic [2:0] {
        S_IDLE, S_PRIME, S_PRE, S_SYNC, S_LEN, S_PAY, S_CRC
    } state_t;

    localparam logic [7:0] PRE_N = 8'(PREAMBLE_BYTES);

    state_t     state_q, state_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] byte_q, byte_d;
    logic [7:0] len_q, len_d;
    logic [7:0] crc_q, crc_d;
    logic       done_q, done_d;
    logic       und_q, und_d;
    logic       last_bit;

    function automatic logic [7:0] crc8_fold(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC_POLY) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    assign last_bit = (bit_q == 3'd7);

    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        len_d    = len_q;
        crc_d    = crc_q;
        done_d   = 1'b0;
        und_d    = 1'b0;
        s_ready  = 1'b0;
        buf_din  = '0;
        buf_load = 1'b0;
        buf_en   = 1'b0;

        if (state_q != S_IDLE && state_q != S_PRIME) begin
            buf_en = 1'b1;
            bit_d  = bit_q + 3'd1;
        end

        // Next byte is loaded on bit 7 of the current one so the stream has no gap.
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = frame_len;
                    crc_d   = CRC_INIT;
                    bit_d   = '0;
                    byte_d  = '0;
                    state_d = S_PRIME;
                end
            end
            S_PRIME: begin
                buf_load = 1'b1;
                buf_din  = PREAMBLE_PAT;
                byte_d   = 8'd1;
                state_d  = S_PRE;
            end
            S_PRE: begin
                if (last_bit) begin
                    buf_load = 1'b1;
                    if (byte_q < PRE_N) begin
                        buf_din = PREAMBLE_PAT;
                        byte_d  = byte_q + 8'd1;
                    end else begin
                        buf_din = SYNC_WORD;
                        state_d = S_SYNC;
                    end
                end
            end
            S_SYNC: begin
                if (last_bit) begin
                    buf_load = 1'b1;
                    buf_din  = len_q;
                    crc_d    = crc8_fold(crc_q, len_q);
                    byte_d   = '0;
                    state_d  = S_LEN;
                end
            end
            S_LEN, S_PAY: begin
                // byte_q counts payload bytes already loaded.
                if (last_bit) begin
                    if (byte_q == len_q) begin
                        buf_load = 1'b1;
                        buf_din  = crc_q;
                        state_d  = S_CRC;
                    end else begin
                        s_ready = 1'b1;
                        if (s_valid) begin
                            buf_load = 1'b1;
                            buf_din  = s_data;
                            crc_d    = crc8_fold(crc_q, s_data);
                            byte_d   = byte_q + 8'd1;
                            state_d  = S_PAY;
                        end else begin
                            und_d   = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            S_CRC: begin
                if (last_bit) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            bit_q   <= '0;
            byte_q  <= '0;
            len_q   <= '0;
            crc_q   <= CRC_INIT;
            done_q  <= 1'b0;
            und_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            len_q   <= len_d;
            crc_q   <= crc_d;
            done_q  <= done_d;
            und_q   <= und_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign underrun = und_q;

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// Scoreboard bench for tx_frame_ctrl: expected loaded bytes are queued by the
// stimulus and checked by per-instance monitors on every buf_load.
module tb_tx_frame_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // instance a: default parameters
    logic       a_rst, a_start, a_valid, a_rdy, a_load, a_en, a_busy, a_done, a_und;
    logic [7:0] a_len, a_data, a_din;
    // instance b: four preamble bytes
    logic       b_rst, b_start, b_valid, b_rdy, b_load, b_en, b_busy, b_done, b_und;
    logic [7:0] b_len, b_data, b_din;

    tx_frame_ctrl u_a (
        .clk(clk), .rst(a_rst), .start(a_start), .frame_len(a_len),
        .s_data(a_data), .s_valid(a_valid), .s_ready(a_rdy),
        .buf_din(a_din), .buf_load(a_load), .buf_en(a_en),
        .busy(a_busy), .done(a_done), .underrun(a_und)
    );

    tx_frame_ctrl #(.PREAMBLE_BYTES(4)) u_b (
        .clk(clk), .rst(b_rst), .start(b_start), .frame_len(b_len),
        .s_data(b_data), .s_valid(b_valid), .s_ready(b_rdy),
        .buf_din(b_din), .buf_load(b_load), .buf_en(b_en),
        .busy(b_busy), .done(b_done), .underrun(b_und)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int ena = 0, rdya = 0, donea = 0, unda = 0, runa = 0, lasta = 0;
    int enb = 0, rdyb = 0, doneb = 0, runb = 0, lastb = 0;

    always @(negedge clk) begin
        if (a_load) begin
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_load_unexpected: got 0x%0h, expected no load", a_din);
            end else chk("a_load_byte", {24'd0, a_din}, {24'd0, qa.pop_front()});
        end
        if (a_en) begin ena++; runa++; end
        else if (runa != 0) begin lasta = runa; runa = 0; end
        if (a_rdy)  rdya++;
        if (a_done) donea++;
        if (a_und)  unda++;
    end

    always @(negedge clk) begin
        if (b_load) begin
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_load_unexpected: got 0x%0h, expected no load", b_din);
            end else chk("b_load_byte", {24'd0, b_din}, {24'd0, qb.pop_front()});
        end
        if (b_en) begin enb++; runb++; end
        else if (runb != 0) begin lastb = runb; runb = 0; end
        if (b_rdy)  rdyb++;
        if (b_done) doneb++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_a_done(input int bound, output int n);
        n = 0;
        while (a_done !== 1'b1 && n < bound) begin step(); n++; end
    endtask

    // Runs one frame on instance a from start to done; expected bytes queued by caller.
    task automatic frame_a(input string tag, input logic [7:0] len, input logic [7:0] data,
                           input int exp_en, input int exp_rdy);
        int e0, r0, d0, n;
        e0 = ena; r0 = rdya; d0 = donea;
        a_len = len; a_data = data; a_valid = 1'b1;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        chk({tag, "_prime_load"}, a_load, 1'b1);
        chk({tag, "_prime_din"}, a_din, 8'hAA);
        chk({tag, "_prime_en"}, a_en, 1'b0);
        chk({tag, "_busy"}, a_busy, 1'b1);
        step();
        chk({tag, "_first_en"}, a_en, 1'b1);
        wait_a_done(400, n);
        chk({tag, "_done"}, a_done, 1'b1);
        chk({tag, "_done_latency"}, n, exp_en);
        chk({tag, "_busy_at_done"}, a_busy, 1'b0);
        chk({tag, "_en_cycles"}, ena - e0, exp_en);
        chk({tag, "_ready_count"}, rdya - r0, exp_rdy);
        step();
        chk({tag, "_done_pulses"}, donea - d0, 1);
        chk({tag, "_en_run"}, lasta, exp_en);
        chk({tag, "_queue_empty"}, qa.size(), 0);
    endtask

    initial begin
        int n, cnt, e0, r0, d0, u0;
        a_rst = 1'b0; a_start = 1'b0; a_len = '0; a_data = '0; a_valid = 1'b0;
        b_rst = 1'b0; b_start = 1'b0; b_len = '0; b_data = '0; b_valid = 1'b0;
        repeat (3) step();
        chk("rst_outputs", {a_din, a_load, a_en, a_busy, a_done, a_und, a_rdy}, 0);
        chk("rst_outputs_b", {b_din, b_load, b_en, b_busy, b_done, b_und, b_rdy}, 0);
        a_rst = 1'b1; b_rst = 1'b1;
        step();

        // one payload byte: crc8(01, 01) = 12
        qa.push_back(8'hAA); qa.push_back(8'hAA); qa.push_back(8'hD3);
        qa.push_back(8'h01); qa.push_back(8'h01); qa.push_back(8'h12);
        frame_a("len1", 8'd1, 8'h01, 48, 1);

        // empty payload: crc8(00) = 00
        qa.push_back(8'hAA); qa.push_back(8'hAA); qa.push_back(8'hD3);
        qa.push_back(8'h00); qa.push_back(8'h00);
        frame_a("len0", 8'd0, 8'h5A, 40, 0);

        // underrun on second payload byte
        e0 = ena; r0 = rdya; d0 = donea; u0 = unda;
        qa.push_back(8'hAA); qa.push_back(8'hAA); qa.push_back(8'hD3);
        qa.push_back(8'h03); qa.push_back(8'h11);
        a_len = 8'd3; a_data = 8'h11; a_valid = 1'b1; a_start = 1'b1;
        step();
        a_start = 1'b0;
        n = 0;
        while (a_rdy !== 1'b1 && n < 100) begin step(); n++; end
        chk("und_first_fetch", a_rdy, 1'b1);
        step();
        a_valid = 1'b0;
        while (a_und !== 1'b1 && n < 100) begin step(); n++; end
        chk("und_pulse", a_und, 1'b1);
        chk("und_busy", a_busy, 1'b0);
        chk("und_en_low", a_en, 1'b0);
        step();
        chk("und_single_pulse", a_und, 1'b0);
        repeat (20) step();
        chk("und_en_cycles", ena - e0, 40);
        chk("und_ready_count", rdya - r0, 2);
        chk("und_no_done", donea - d0, 0);
        chk("und_pulses", unda - u0, 1);
        chk("und_queue_empty", qa.size(), 0);

        // reset at the 20th en cycle
        d0 = donea; u0 = unda;
        qa.push_back(8'hAA); qa.push_back(8'hAA); qa.push_back(8'hD3);
        a_len = 8'd1; a_data = 8'h01; a_valid = 1'b1; a_start = 1'b1;
        step();
        a_start = 1'b0;
        cnt = 0; n = 0;
        while (cnt < 20 && n < 100) begin step(); n++; if (a_en) cnt++; end
        a_rst = 1'b0;
        step();
        chk("mid_rst_outputs", {a_din, a_load, a_en, a_busy, a_done, a_und, a_rdy}, 0);
        a_rst = 1'b1;
        repeat (2) step();
        chk("mid_rst_en_run", lasta, 20);
        chk("mid_rst_no_done", donea - d0, 0);
        chk("mid_rst_no_und", unda - u0, 0);
        chk("mid_rst_queue_empty", qa.size(), 0);
        qa.push_back(8'hAA); qa.push_back(8'hAA); qa.push_back(8'hD3);
        qa.push_back(8'h01); qa.push_back(8'h01); qa.push_back(8'h12);
        frame_a("after_rst", 8'd1, 8'h01, 48, 1);

        // start pulsed and frame_len changed while busy, then start in the done cycle
        d0 = donea; e0 = ena;
        qa.push_back(8'hAA); qa.push_back(8'hAA); qa.push_back(8'hD3);
        qa.push_back(8'h00); qa.push_back(8'h00);
        a_len = 8'd0; a_valid = 1'b1; a_start = 1'b1;
        step();
        chk("ign_prime_load", a_load, 1'b1);
        for (int i = 0; i < 30; i++) begin
            a_start = (i % 2 == 0);
            a_len = 8'd5;
            step();
        end
        a_start = 1'b0;
        wait_a_done(100, n);
        chk("ign_done", a_done, 1'b1);
        chk("ign_en_cycles", ena - e0, 40);
        qa.push_back(8'hAA); qa.push_back(8'hAA); qa.push_back(8'hD3);
        qa.push_back(8'h00); qa.push_back(8'h00);
        a_len = 8'd0; a_start = 1'b1;
        step();
        a_start = 1'b0;
        chk("b2b_prime_load", a_load, 1'b1);
        chk("b2b_prime_din", a_din, 8'hAA);
        chk("b2b_busy", a_busy, 1'b1);
        wait_a_done(100, n);
        chk("b2b_done", a_done, 1'b1);
        chk("b2b_done_latency", n, 41);
        step();
        chk("b2b_done_pulses", donea - d0, 2);
        chk("b2b_queue_empty", qa.size(), 0);

        // four preamble bytes, payload FF 00: crc8(02 FF 00) = 01
        for (int i = 0; i < 4; i++) qb.push_back(8'hAA);
        qb.push_back(8'hD3); qb.push_back(8'h02);
        qb.push_back(8'hFF); qb.push_back(8'h00); qb.push_back(8'h01);
        b_len = 8'd2; b_data = 8'hFF; b_valid = 1'b1; b_start = 1'b1;
        step();
        b_start = 1'b0;
        chk("pb4_prime_load", b_load, 1'b1);
        n = 0;
        while (b_rdy !== 1'b1 && n < 200) begin step(); n++; end
        chk("pb4_first_fetch", b_rdy, 1'b1);
        step();
        b_data = 8'h00;
        while (b_done !== 1'b1 && n < 200) begin step(); n++; end
        chk("pb4_done", b_done, 1'b1);
        chk("pb4_busy_at_done", b_busy, 1'b0);
        chk("pb4_en_cycles", enb, 72);
        step();
        chk("pb4_en_run", lastb, 72);
        chk("pb4_ready_count", rdyb, 2);
        chk("pb4_done_pulses", doneb, 1);
        chk("pb4_queue_empty", qb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tx_frame_ctrl.md
Name: tx_frame_ctrl

Overview:
- Framing controller directly upstream of the TX parallel-to-serial shift buffer.
- Accepts a frame request (length) and payload bytes over a valid/ready stream.
- Drives the shift buffer's din/load/en so it emits a gapless serial frame: preamble, sync word, length, payload, then CRC-8.
- The shift buffer behaves as follows:
  - load captures din.
  - Each en cycle registers the MSB to dout and shifts left.
  - load and en together shift out the old MSB and capture the new byte.

Parameters:
- PREAMBLE_BYTES, 2, number of preamble bytes (legal 1..15).
- PREAMBLE_PAT, 8'hAA, preamble byte value.
- SYNC_WORD, 8'hD3, sync byte sent after the preamble.
- CRC_POLY, 8'h07, CRC-8 polynomial; MSB-first, no reflection, no final XOR.
- CRC_INIT, 8'h00, CRC register value at frame start.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-low reset (rst==0 resets on clk edge).
- start  input  1  frame request; sampled only in IDLE.
- frame_len  input  8  payload byte count (0..255); latched on accepted start.
- s_data  input  8  payload byte.
- s_valid  input  1  s_data valid.
- s_ready  output  1  combinational; high only in the cycle a payload byte is consumed.
- buf_din  output  8  byte to shift buffer.
- buf_load  output  1  shift buffer load strobe.
- buf_en  output  1  shift buffer shift enable.
- busy  output  1  high from accepted start until final en cycle inclusive.
- done  output  1  one-cycle pulse after the final en cycle.
- underrun  output  1  one-cycle pulse on payload underrun abort.

Behaviour:
- Reset (rst==0): state IDLE; buf_din=0, buf_load=0, buf_en=0, busy=0, done=0, underrun=0, s_ready=0; bit and byte counters cleared; CRC=CRC_INIT. Reset mid-frame abandons the frame with no done or underrun pulse.
- States: IDLE, PRIME, PRE, SYNC, LEN, PAY, CRC.
  - IDLE: start=1 latches frame_len, clears CRC, goes to PRIME, sets busy.
  - PRIME: one cycle with buf_load=1, buf_en=0, buf_din=PREAMBLE_PAT. Then PRE.
  - Every state other than IDLE and PRIME holds buf_en=1 for exactly 8 cycles per byte, tracked by a 3-bit bit_cnt.
  - When bit_cnt==7 and another byte follows, assert buf_load with the next byte in the same cycle, so there is no gap between bytes.
- Byte order: PREAMBLE_PAT ×PREAMBLE_BYTES, SYNC_WORD, frame_len, payload[0..N-1], CRC.
- CRC:
  - Covers the length byte and the payload only.
  - Each byte is folded in the cycle it is loaded.
  - The CRC byte loaded is the registered value after the last payload byte (after the length byte if N=0).
- Payload fetch:
  - In the load cycle for a payload byte, s_ready=1 and buf_din=s_data pass straight through.
  - A transfer happens when s_valid&s_ready.
  - s_ready is 0 in all other cycles.
- Underrun: if s_valid=0 in a payload load cycle:
  - no load; buf_en drops the next cycle;
  - underrun pulses for one cycle; return to IDLE; busy=0; no CRC is sent; no done pulse.
- frame_len=0: LEN goes straight to CRC, and CRC = crc8(0x00) with default parameters = 0x00.
- Timing, with start accepted at cycle T:
  - load at T+1; first buf_en at T+2; first serial bit on the buffer's dout at T+3.
  - Total en cycles = 8×(PREAMBLE_BYTES+3+N).
  - done pulses the cycle after the last en cycle, with busy=0 in that same cycle.
  - A new start is accepted in the done cycle.
- start while busy is ignored; frame_len changes while busy have no effect.
- Simultaneous rst==0 and start: reset wins.

Test Plan:
- Defaults, start with frame_len=1, s_data=0x01 held valid:
  - buf_load at T+1 with 0xAA;
  - 48 consecutive buf_en cycles;
  - loaded bytes AA, AA, D3, 01, 01, 12;
  - s_ready high exactly once;
  - done at T+50.
- frame_len=0 -> bytes AA, AA, D3, 00, 00; 40 en cycles; s_ready never asserted; done pulses once.
- frame_len=3, s_valid deasserted at the second payload load cycle:
  - underrun pulses once; buf_en low the next cycle; busy=0; no CRC byte; no done.
- rst driven to 0 at the 20th en cycle -> next cycle all outputs 0, state IDLE; start after release gives a clean full frame.
- start pulsed repeatedly while busy -> ignored; exactly one frame and one done. start in the done cycle -> second frame's PRIME load is the next cycle.
- PREAMBLE_BYTES=4, frame_len=2, payload 0xFF,0x00:
  - bytes AA×4, D3, 02, FF, 00, then CRC matching the reference model;
  - bit stream contiguous, with no buf_en gap.
